instruction_fetch: RTL and testbench

Fetch stage for the 5-bit-PC, 32-bit-instruction core. Owns the program counter, drives the address of the combinational instruction memory, and captures each returned word with its PC into a 2-entry buffer. It hands these entries to the decode stage over a valid/ready handshake. Supports redirect of the PC with a buffer flush, and stops fetching after a programmable last address.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instruction_fetch_if.sv | 17 +
 rtl/fetch_buffer.sv | 78 +++++++
 rtl/instruction_fetch.sv | 100 ++++++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-bit-PC, 32-bit-instruction core.
//   PC_W / INSTR_W : program counter and instruction widths
//   OP_*           : major opcode encodings (instr[31:29])
//   fetch_entry_t  : one fetched instruction tagged with its address
package cpu_pkg;

    localparam int unsigned PC_W    = 5;
    localparam int unsigned INSTR_W = 32;

    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SHIFTL = 3'b100;
    localparam logic [2:0] OP_ADDI   = 3'b110;
    localparam logic [2:0] OP_SUBI   = 3'b111;

    localparam logic [7:0] ISSUE_MAX = 8'd255;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake.
//   out_valid : head entry present (driven by fetch)
//   out_ready : decode accepts the head this cycle (driven by decode)
//   out_instr : head instruction
//   out_pc    : address of the head instruction
interface instruction_fetch_if;
    import cpu_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (output out_valid, output out_instr, output out_pc, input out_ready);
    modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : enqueue push_entry (caller guarantees space, or a same-cycle pop)
//   pop        : drop the head (caller guarantees count != 0)
//   flush      : empty the buffer; overrides push and pop
//   head       : oldest entry, all zero while empty
//   count      : number of occupied entries (0..2)
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    // slot0 is always the head; unused slots are kept at zero so head reads 0 when empty.
    fetch_entry_t slot0_q, slot0_d;
    fetch_entry_t slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            slot0_d = '0;
            slot1_d = '0;
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_d = push_entry;
                    end else begin
                        slot1_d = push_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    slot1_d = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: shift when full, otherwise replace the lone head.
                    if (count_q == 2'd2) begin
                        slot0_d = slot1_q;
                        slot1_d = push_entry;
                    end else begin
                        slot0_d = push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head  = slot0_q;
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory, buffers
// returned words in a 2-entry FIFO and hands them to decode over valid/ready.
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem_addr      : instruction memory address (the PC)
//   imem_instr     : word at imem_addr, same cycle
//   out            : decode handshake (master side)
//   redirect_valid : load PC from redirect_pc, flush the buffer, restart fetching
//   redirect_pc    : new fetch address
//   done           : fetch stopped and buffer empty (registered)
//   issue_count    : completed output handshakes, saturating at 255
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] LAST_PC = 5'd31
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    instruction_fetch_if.master out,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                done,
    output logic [7:0]          issue_count
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            stopped_q, stopped_d;
    logic            done_q, done_d;
    logic [7:0]      issue_q, issue_d;

    logic            push;
    logic            pop;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign pop  = out.out_valid && out.out_ready;
    // A full buffer may still accept a word when its head leaves this cycle.
    assign push = !stopped_q && !redirect_valid && ((count != 2'd2) || pop);

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_instr;

    fetch_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        pc_d      = pc_q;
        stopped_d = stopped_q;
        issue_d   = issue_q;
        done_d    = stopped_q && (count == 2'd0);
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            stopped_d = 1'b0;
        end else if (push) begin
            if (pc_q == LAST_PC) begin
                stopped_d = 1'b1;
            end else begin
                pc_d = pc_q + PC_ONE;
            end
        end
        // The handshake in a redirect cycle still counts.
        if (pop && (issue_q != ISSUE_MAX)) begin
            issue_d = issue_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            stopped_q <= 1'b0;
            done_q    <= 1'b0;
            issue_q   <= 8'd0;
        end else begin
            pc_q      <= pc_d;
            stopped_q <= stopped_d;
            done_q    <= done_d;
            issue_q   <= issue_d;
        end
    end

    assign imem_addr     = pc_q;
    assign out.out_valid = (count != 2'd0);
    assign out.out_instr = head.instr;
    assign out.out_pc    = head.pc;
    assign done          = done_q;
    assign issue_count   = issue_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one instance with LAST_PC = 5 (short program,
// redirect after done) and one with LAST_PC = 31 (backpressure, redirect flush, wrap,
// asynchronous reset). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, i.e. after the preceding edge has settled.
module tb_instruction_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;

    logic [PC_W-1:0]    imem_addr5,  imem_addr31;
    logic [INSTR_W-1:0] imem_instr5, imem_instr31;
    logic               redir_v5,    redir_v31;
    logic [PC_W-1:0]    redir_pc5,   redir_pc31;
    logic               done5,       done31;
    logic [7:0]         issue5,      issue31;

    instruction_fetch_if if5 ();
    instruction_fetch_if if31 ();

    int n_cmp;
    int n_err;

    // Program image: address 0 holds 0xC050000A, the rest are ADDI words tagged with the address.
    function automatic logic [INSTR_W-1:0] rom_word(input logic [PC_W-1:0] a);
        if (a == 5'd0) return 32'hC050_000A;
        return {OP_ADDI, 24'h00_0000, a};
    endfunction

    assign imem_instr5  = rom_word(imem_addr5);
    assign imem_instr31 = rom_word(imem_addr31);

    instruction_fetch #(.LAST_PC(5'd5)) dut5 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr5),
        .imem_instr     (imem_instr5),
        .out            (if5),
        .redirect_valid (redir_v5),
        .redirect_pc    (redir_pc5),
        .done           (done5),
        .issue_count    (issue5)
    );

    instruction_fetch #(.LAST_PC(5'd31)) dut31 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr31),
        .imem_instr     (imem_instr31),
        .out            (if31),
        .redirect_valid (redir_v31),
        .redirect_pc    (redir_pc31),
        .done           (done31),
        .issue_count    (issue31)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        redir_v5 = 1'b0;  redir_pc5 = '0;  if5.out_ready = 1'b1;
        redir_v31 = 1'b0; redir_pc31 = '0; if31.out_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check_eq("rst_valid", 32'(if5.out_valid), 32'd0);
        check_eq("rst_pc", 32'(if5.out_pc), 32'd0);
        check_eq("rst_instr", if5.out_instr, 32'd0);
        check_eq("rst_addr", 32'(imem_addr5), 32'd0);
        check_eq("rst_done", 32'(done5), 32'd0);
        check_eq("rst_issue", 32'(issue5), 32'd0);
        rst_n = 1'b1;

        // ---------------- program 0, LAST_PC = 5, out_ready = 1 ----------------
        step();
        check_eq("p0_valid0", 32'(if5.out_valid), 32'd1);
        check_eq("p0_pc0", 32'(if5.out_pc), 32'd0);
        check_eq("p0_instr0", if5.out_instr, 32'hC050_000A);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq("p0_valid", 32'(if5.out_valid), 32'd1);
            check_eq("p0_pc", 32'(if5.out_pc), 32'(k));
            check_eq("p0_instr", if5.out_instr, {OP_ADDI, 24'h00_0000, 5'(k)});
        end
        check_eq("p0_addr_hold", 32'(imem_addr5), 32'd5);
        step();  // edge retiring the last handshake
        check_eq("p0_empty", 32'(if5.out_valid), 32'd0);
        check_eq("p0_done_early", 32'(done5), 32'd0);
        check_eq("p0_issue6", 32'(issue5), 32'd6);
        step();
        check_eq("p0_done", 32'(done5), 32'd1);
        check_eq("p0_addr_stop", 32'(imem_addr5), 32'd5);

        // ---------------- redirect after done ----------------
        redir_v5 = 1'b1; redir_pc5 = 5'd2;
        step();
        redir_v5 = 1'b0;
        check_eq("rad_bubble", 32'(if5.out_valid), 32'd0);
        check_eq("rad_addr", 32'(imem_addr5), 32'd2);
        step();
        check_eq("rad_valid", 32'(if5.out_valid), 32'd1);
        check_eq("rad_pc", 32'(if5.out_pc), 32'd2);
        check_eq("rad_done_fall", 32'(done5), 32'd0);
        check_eq("rad_issue", 32'(issue5), 32'd6);

        // ---------------- backpressure on LAST_PC = 31 instance ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        if31.out_ready = 1'b0;
        step();
        check_eq("bp_count1", 32'(dut31.u_buf.count), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            step();
            check_eq("bp_count2", 32'(dut31.u_buf.count), 32'd2);
            check_eq("bp_addr", 32'(imem_addr31), 32'd2);
            check_eq("bp_pc", 32'(if31.out_pc), 32'd0);
            check_eq("bp_valid", 32'(if31.out_valid), 32'd1);
        end
        if31.out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_eq("bp_seq_pc", 32'(if31.out_pc), 32'(k));
            check_eq("bp_seq_instr", if31.out_instr, {OP_ADDI, 24'h00_0000, 5'(k)});
        end
        check_eq("bp_issue3", 32'(issue31), 32'd3);

        // ---------------- redirect flush: buffer holds 3, 4 ----------------
        check_eq("rd_count", 32'(dut31.u_buf.count), 32'd2);
        redir_v31 = 1'b1; redir_pc31 = 5'd1;
        step();
        redir_v31 = 1'b0;
        check_eq("rd_bubble", 32'(if31.out_valid), 32'd0);
        check_eq("rd_issue4", 32'(issue31), 32'd4);
        check_eq("rd_addr", 32'(imem_addr31), 32'd1);
        step();
        check_eq("rd_valid", 32'(if31.out_valid), 32'd1);
        check_eq("rd_pc", 32'(if31.out_pc), 32'd1);

        // ---------------- wrap: redirect to 30, stop after 31 ----------------
        redir_v31 = 1'b1; redir_pc31 = 5'd30;
        step();
        redir_v31 = 1'b0;
        check_eq("wr_bubble", 32'(if31.out_valid), 32'd0);
        check_eq("wr_issue5", 32'(issue31), 32'd5);
        step();
        check_eq("wr_pc30", 32'(if31.out_pc), 32'd30);
        step();
        check_eq("wr_pc31", 32'(if31.out_pc), 32'd31);
        check_eq("wr_addr31", 32'(imem_addr31), 32'd31);
        step();
        check_eq("wr_empty", 32'(if31.out_valid), 32'd0);
        check_eq("wr_addr_hold", 32'(imem_addr31), 32'd31);
        step();
        check_eq("wr_done", 32'(done31), 32'd1);
        check_eq("wr_no_wrap", 32'(if31.out_valid), 32'd0);
        check_eq("wr_issue7", 32'(issue31), 32'd7);

        // ---------------- asynchronous reset mid-stream ----------------
        redir_v31 = 1'b1; redir_pc31 = 5'd10;
        step();
        redir_v31 = 1'b0;
        step();
        step();
        step();
        check_eq("ar_pre_valid", 32'(if31.out_valid), 32'd1);
        check_eq("ar_pre_pc", 32'(if31.out_pc), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 32'(if31.out_valid), 32'd0);
        check_eq("ar_addr", 32'(imem_addr31), 32'd0);
        check_eq("ar_issue", 32'(issue31), 32'd0);
        check_eq("ar_done", 32'(done31), 32'd0);
        step();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
